ysyx_22040386_lsu: RTL
======================

// Module: ysyx_22040386_lsu
// PURPOSE
//   Load/store unit between the core datapath and a handshaked data-memory port. Replaces the
//   zero-latency combinational data access with a multi-cycle request/response transaction.
//   Accepts one access from EXU, issues one 8-byte-aligned bus beat, and returns the load result.
//   Load results are lane-shifted and sign/zero-extended. Store data is lane-shifted and byte-masked.
// PARAMETERS
//   TIMEOUT  255  cycles waited in WAIT for mem_resp_valid before the access is aborted with error
// PORTS
//   clk             in   1   core clock, all state on posedge
//   rst_n           in   1   asynchronous active-low reset
//   req_valid       in   1   EXU access request
//   req_ready       out  1   LSU can accept (high only in IDLE)
//   req_wen         in   1   1=store, 0=load
//   req_addr        in   64  byte address
//   req_wdata       in   64  store data, right-aligned
//   req_size        in   2   0=byte 1=half 2=word 3=dword
//   req_unsigned    in   1   load zero-extend (LBU/LHU/LWU); ignored for size 3 and for stores
//   resp_valid      out  1   one-cycle completion pulse
//   resp_rdata      out  64  extended load data; 0 for stores and errors
//   resp_err        out  1   access failed (timeout, bus error, misalign trap)
//   mem_req_valid   out  1   bus request
//   mem_req_ready   in   1   bus accepts request
//   mem_addr        out  64  {req_addr[63:3],3'b000}
//   mem_wen         out  1   bus write
//   mem_wdata       out  64  req_wdata << (8*addr[2:0])
//   mem_wmask       out  8   byte enables (stores); 8'h00 for loads
//   mem_resp_valid  in   1   bus response
//   mem_resp_rdata  in   64  aligned 8-byte read data
//   mem_resp_err    in   1   bus error, valid with mem_resp_valid
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0, mem_req_valid=0,
//     mem_addr=0, mem_wen=0, mem_wdata=0, mem_wmask=0, timeout counter=0. Reset mid-transaction
//     abandons it; any later mem_resp_valid in IDLE is ignored.
//   FSM IDLE->REQ->WAIT->DONE->IDLE:
//     IDLE: req_ready=1. On req_valid: latch addr[2:0], size, unsigned, wen; drive mem_* regs; ->REQ.
//     REQ:  mem_req_valid=1, held with mem_addr/wdata/wmask/wen stable until mem_req_ready; ->WAIT.
//     WAIT: mem_resp_valid sampled only here. On it: capture formatted data/err; ->DONE.
//           Counter increments each WAIT cycle; reaching TIMEOUT -> DONE, resp_err=1, resp_rdata=0.
//     DONE: resp_valid=1 exactly one cycle; ->IDLE (next request accepted the following cycle).
//   Min latency (ready/resp immediate): accept t0, bus handshake t1, resp t2, resp_valid t3.
//   Store mask: base {01,03,0F,FF}[size] << addr[2:0], truncated to 8 bits.
//   Load: s = mem_resp_rdata >> (8*addr[2:0]); take low 8/16/32/64 bits; sign-extend from the
//     top bit unless req_unsigned. Store response: resp_rdata=0, resp_err=mem_resp_err.
//   mem_resp_err=1 on a load: resp_rdata=0, resp_err=1.
//   Non-doubleword-crossing misaligned accesses (e.g. half at offset 1) are legal and served.
// CONFIGURATION
//   MISALIGN_TRAP_EN defined: an access with addr not aligned to 1<<size issues no bus beat;
//     IDLE->DONE directly, resp_valid one cycle after accept with resp_err=1, resp_rdata=0.
//   Not defined: no alignment check; bytes past the doubleword boundary are dropped (mask/shift
//     truncation), resp_err=0.
// TESTING
//   LD addr=0x80000008, mem returns 0x1122334455667788, zero-wait bus -> resp_valid at t3,
//     rdata=0x1122334455667788, mem_addr=0x80000008, mem_wmask=8'h00.
//   LB addr=0x80000003, rdata 0x00000000_80000000 -> resp_rdata=0xFFFFFFFFFFFFFF80; LBU -> 0x80.
//   SH addr=0x80000002, wdata=0xBEEF -> mem_wmask=8'h0C, mem_wdata=0x00000000BEEF0000, resp_rdata=0.
//   mem_req_ready low 5 cycles -> mem_req_valid/mem_addr held stable, resp_valid at t8, req_ready=0 throughout.
//   No mem_resp_valid for TIMEOUT cycles -> one resp_valid pulse with resp_err=1; rst_n pulsed in WAIT
//     -> all outputs 0 immediately, req_ready=1 after release, stray mem_resp_valid ignored.
//   SW addr=0x80000006: MISALIGN_TRAP_EN -> no mem_req_valid, resp_err=1 at t1; otherwise
//     mem_wmask=8'hC0, resp_err=0.

Source files
------------

// File: rtl/ysyx_22040386_lsu.sv
// Load/store unit: one EXU access becomes one aligned 8-byte handshaked bus beat.
// Optional MISALIGN_TRAP_EN: misaligned accesses skip the bus and complete with resp_err.
module ysyx_22040386_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_addr,
  output logic        mem_wen,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_resp_rdata,
  input  logic        mem_resp_err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t        state, state_nxt;
  logic [2:0]    off;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [CW-1:0] cnt;
  logic          cnt_last;
  logic          trap;
  logic [7:0]    mask_base;
  logic [63:0]   shifted;
  logic [63:0]   load_val;

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    trap = 1'b0;
    unique case (req_size)
      2'd0: trap = 1'b0;
      2'd1: trap = req_addr[0];
      2'd2: trap = |req_addr[1:0];
      2'd3: trap = |req_addr[2:0];
      default: trap = 1'b0;
    endcase
  end
`else
  assign trap = 1'b0;
`endif

  assign req_ready     = (state == IDLE);
  assign mem_req_valid = (state == REQ);
  assign resp_valid    = (state == DONE);
  assign cnt_last      = (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    mask_base = 8'h00;
    unique case (req_size)
      2'd0: mask_base = 8'h01;
      2'd1: mask_base = 8'h03;
      2'd2: mask_base = 8'h0F;
      2'd3: mask_base = 8'hFF;
      default: mask_base = 8'h00;
    endcase
  end

  always_comb begin
    shifted  = mem_resp_rdata >> {off, 3'b000};
    load_val = shifted;
    unique case (size_q)
      2'd0: load_val = uns_q ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}}, shifted[7:0]};
      2'd1: load_val = uns_q ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'd2: load_val = uns_q ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      2'd3: load_val = shifted;
      default: load_val = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_valid) state_nxt = trap ? DONE : REQ;
      REQ:     if (mem_req_ready) state_nxt = WAIT;
      WAIT:    if (mem_resp_valid || cnt_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off        <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      cnt        <= '0;
      mem_addr   <= '0;
      mem_wen    <= 1'b0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (req_valid) begin
          off        <= req_addr[2:0];
          size_q     <= req_size;
          uns_q      <= req_unsigned;
          cnt        <= '0;
          mem_addr   <= {req_addr[63:3], 3'b000};
          mem_wen    <= req_wen;
          mem_wdata  <= req_wdata << {req_addr[2:0], 3'b000};
          // lanes past the doubleword boundary fall off the 8-bit mask
          mem_wmask  <= req_wen ? (mask_base << req_addr[2:0]) : 8'h00;
          resp_rdata <= '0;
          resp_err   <= trap;
        end
        WAIT: begin
          if (mem_resp_valid) begin
            resp_err   <= mem_resp_err;
            resp_rdata <= (mem_wen || mem_resp_err) ? '0 : load_val;
          end else if (cnt_last) begin
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
